// File: rtl/mux_accum_seq.sv
// mux_accum_seq: walks a 4:1 upstream operand mux through sel=0..3 and sums
// the operands enabled by a mask captured at start. Fixed 6-edge latency from
// start acceptance to the done pulse; sum/ovf4 hold until the next pass.
module mux_accum_seq #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   mask,
  output logic [1:0]   sel,
  input  logic [W-1:0] y_in,
  output logic [W+1:0] sum,
  output logic         ovf4,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [W+1:0] LIM = {2'b00, {W{1'b1}}};

  state_t       state;
  logic [3:0]   mask_r;
  logic [W+1:0] acc;
  logic [W+1:0] term;
  logic [W+1:0] nxt;

  // current operand contribution and running total including it
  always_comb begin
    term = mask_r[sel] ? {2'b00, y_in} : '0;
    nxt  = acc + term;
  end

  // control FSM; all outputs registered. done rises on the DONE->IDLE edge so
  // it is seen in the IDLE cycle that can already accept the next start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sel    <= '0;
      acc    <= '0;
      mask_r <= '0;
      sum    <= '0;
      ovf4   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          sel  <= '0;
          if (start) begin
            mask_r <= mask;
            acc    <= '0;
            busy   <= 1'b1;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          done <= 1'b0;
          acc  <= nxt;
          if (sel == 2'd3) begin
            sum   <= nxt;
            ovf4  <= (nxt > LIM);
            state <= DONE;
          end else begin
            sel <= sel + 2'd1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          sel   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          sel   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_accum_seq.sv
// Scoreboard bench for mux_accum_seq: the driver pushes the hand-computed
// result and the cycle the done pulse is due; an independent monitor pops on
// every done and compares.
module tb_mux_accum_seq;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   mask;
  logic [1:0]   sel;
  logic [W-1:0] y_in;
  logic [W+1:0] sum;
  logic         ovf4;
  logic         busy;
  logic         done;

  logic [W-1:0] ops [4];

  typedef struct {
    logic [W+1:0] s;
    logic         o;
    int           c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vec = 0;
  int   err = 0;

  mux_accum_seq #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .mask(mask), .sel(sel),
    .y_in(y_in), .sum(sum), .ovf4(ovf4), .busy(busy), .done(done)
  );

  // upstream 4:1 operand mux
  assign y_in = ops[sel];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    vec++;
    if (act !== req) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding pass
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        vec++; err++;
        $display("FAIL unexpected_done: got done=1 expected no pass pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc, e.c);
        chk("sum", int'(sum), int'(e.s));
        chk("ovf4", int'(ovf4), int'(e.o));
      end
    end
  end

  task automatic set_ops(input logic [W-1:0] a, b, c, d);
    ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = d;
  endtask

  // one pass, entered and left at a negedge. With start raised here, the
  // accepting edge is cyc+1 and done is due after edge cyc+6.
  task automatic pass(input logic [3:0] m, input logic [W+1:0] es, input logic eo,
                      input bit flip, input bit keep);
    exp_t e;
    mask = m; start = 1'b1;
    e.s = es; e.o = eo; e.c = cyc + 6;
    q.push_back(e);
    @(negedge clk);
    if (!keep) start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sel_step", int'(sel), i);
      chk("busy_accum", int'(busy), 1);
      if (flip && i == 1) mask = ~m;
      @(negedge clk);
    end
    chk("sel_hold_done", int'(sel), 3);
    chk("busy_done_state", int'(busy), 1);
    chk("no_early_done", int'(done), 0);
    @(negedge clk);
    chk("sel_back_0", int'(sel), 0);
    chk("busy_idle", int'(busy), 0);
    if (!keep) start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mask = 4'hF;
    set_ops(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    chk("rst_sum", int'(sum), 0);
    chk("rst_ovf4", int'(ovf4), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sel", int'(sel), 0);
    reset = 1'b0;
    @(negedge clk);

    // a..d = 3,5,7,9
    set_ops(4'd3, 4'd5, 4'd7, 4'd9);
    pass(4'b1111, 6'd24, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold_sum", int'(sum), 24);
    chk("hold_ovf4", int'(ovf4), 1);
    pass(4'b0101, 6'd10, 1'b0, 1'b0, 1'b0);

    set_ops(4'd15, 4'd15, 4'd15, 4'd15);
    pass(4'b1111, 6'd60, 1'b1, 1'b0, 1'b0);
    pass(4'b0000, 6'd0, 1'b0, 1'b0, 1'b0);
    pass(4'b1000, 6'd15, 1'b0, 1'b0, 1'b0);

    // start held high, mask flipped mid-pass: result uses 0011 -> 3+5,
    // then the held start is taken straight after done with mask 1010 -> 5+9
    set_ops(4'd3, 4'd5, 4'd7, 4'd9);
    pass(4'b0011, 6'd8, 1'b0, 1'b1, 1'b1);
    chk("b2b_busy", int'(busy), 0);
    pass(4'b1010, 6'd14, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("one_pass_only_busy", int'(busy), 0);

    // reset in the second ACCUM cycle aborts the pass
    mask = 4'b1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_pre_sel", int'(sel), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_sel", int'(sel), 0);
    chk("abort_sum", int'(sum), 0);
    chk("abort_done", int'(done), 0);
    repeat (8) @(negedge clk);

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
